// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave controller.
//   SPI_MODE0         : {CPOL, CPHA} encoding of the only supported mode
//   DEFAULT_WIDTH     : default bits per SPI word
//   DEFAULT_IDLE_FILL : default word shifted out when the tx buffer is empty
//   spi_state_e       : frame state of the slave controller
package spi_pkg;

  localparam logic [1:0]  SPI_MODE0         = 2'b00;
  localparam int unsigned DEFAULT_WIDTH     = 8;
  localparam logic [7:0]  DEFAULT_IDLE_FILL = 8'hFF;

  typedef enum logic {
    StIdle,
    StActive
  } spi_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input with edge pulses.
//   clk     : system clock
//   reset   : synchronous, active-high reset
//   d_i     : asynchronous input
//   level_o : synchronised level
//   rise_o  : one-cycle pulse on a synchronised 0->1 transition
//   fall_o  : one-cycle pulse on a synchronised 1->0 transition
// All flops reset to 0, so an input that is already low at reset produces no
// fall pulse; an input high at reset produces one rise pulse.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave_controller.sv
// SPI mode-0 (CPOL=0, CPHA=0, MSB first) byte-oriented slave.
// The SPI pins are oversampled on clk; MOSI is deserialised into rx words and a
// one-deep tx buffer is serialised onto MISO.
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   cs_n_i     : chip select from master, active-low, asynchronous
//   sck_i      : SPI clock from master, asynchronous
//   mosi_i     : master-out data, asynchronous
//   miso_o     : slave-out data, registered
//   tx_data_i  : word to send in the next frame slot
//   tx_load_i  : write strobe for tx_data_i, accepted only while tx_ready_o=1
//   tx_ready_o : tx buffer empty
//   rx_data_o  : last complete received word, held until the next one
//   rx_valid_o : one-cycle pulse, rx_data_o updated
//   busy_o     : synchronised chip select asserted (frame active)
//   underrun_o : one-cycle pulse, IDLE_FILL sent because the buffer was empty
//   frame_err_o: one-cycle pulse, chip select released mid-word
module spi_slave_controller
  import spi_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_FILL   = WIDTH'(DEFAULT_IDLE_FILL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs_n_i,
  input  logic             sck_i,
  input  logic             mosi_i,
  output logic             miso_o,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_load_i,
  output logic             tx_ready_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             busy_o,
  output logic             underrun_o,
  output logic             frame_err_o
);

  localparam int unsigned    CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  // Synchronised pins
  logic cs_level, cs_rise, cs_fall;
  logic sck_rise, sck_fall, unused_sck_level;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_bit;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_cs (
    .clk    (clk),
    .reset  (reset),
    .d_i    (cs_n_i),
    .level_o(cs_level),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_sck (
    .clk    (clk),
    .reset  (reset),
    .d_i    (sck_i),
    .level_o(unused_sck_level),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  // MOSI shares the pipeline depth of sck so data and its sampling edge stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    end
  end
  assign mosi_bit = mosi_sync_q[SYNC_STAGES-1];

  // State
  spi_state_e       state_q;
  logic             arm_q;
  logic [CntW-1:0]  bit_cnt_q;
  logic             word_done_q;
  logic [WIDTH-1:0] rx_shift_q;
  logic [WIDTH-1:0] tx_shift_q;
  logic [WIDTH-1:0] buf_q;
  logic             buf_full_q;
  logic             miso_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             busy_q;
  logic             underrun_q;
  logic             frame_err_q;

  // Load-point decode
  logic             frame_start, word_load, load_point, load_underrun;
  logic [WIDTH-1:0] load_word, rx_word;

  // arm_q stays low after reset until cs_n is seen high, so a frame already in
  // progress at reset is ignored until a fresh cs_n fall.
  assign frame_start = (state_q == StIdle) && arm_q && cs_fall;
  // A cs_n rise beats any coincident sck edge.
  assign word_load   = (state_q == StActive) && !cs_rise && sck_fall && word_done_q;
  assign load_point  = frame_start || word_load;
  assign rx_word     = {rx_shift_q[WIDTH-2:0], mosi_bit};

  // A tx_load arriving on the load point bypasses the empty buffer.
  always_comb begin
    load_word     = IDLE_FILL;
    load_underrun = 1'b0;
    if (buf_full_q) begin
      load_word = buf_q;
    end else if (tx_load_i) begin
      load_word = tx_data_i;
    end else begin
      load_underrun = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      arm_q       <= 1'b0;
      bit_cnt_q   <= '0;
      word_done_q <= 1'b0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= arm_q & ~cs_level;
      if (cs_level) begin
        arm_q <= 1'b1;
      end

      // tx buffer: a load point always leaves it empty
      if (load_point) begin
        buf_full_q <= 1'b0;
      end else if (tx_load_i && !buf_full_q) begin
        buf_q      <= tx_data_i;
        buf_full_q <= 1'b1;
      end

      if (load_point) begin
        tx_shift_q  <= load_word;
        miso_q      <= load_word[WIDTH-1];
        underrun_q  <= load_underrun;
        word_done_q <= 1'b0;
        bit_cnt_q   <= '0;
      end

      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            state_q <= StActive;
          end
        end
        StActive: begin
          if (cs_rise) begin
            state_q     <= StIdle;
            miso_q      <= 1'b0;
            word_done_q <= 1'b0;
            bit_cnt_q   <= '0;
            if (bit_cnt_q != '0) begin
              frame_err_q <= 1'b1;
            end
          end else if (sck_rise) begin
            rx_shift_q <= rx_word;
            if (bit_cnt_q == LastBit) begin
              rx_data_q   <= rx_word;
              rx_valid_q  <= 1'b1;
              bit_cnt_q   <= '0;
              word_done_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end else if (sck_fall && !word_done_q) begin
            tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
            miso_q     <= tx_shift_q[WIDTH-2];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign miso_o      = miso_q;
  assign tx_ready_o  = ~buf_full_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign busy_o      = busy_q;
  assign underrun_o  = underrun_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_spi_slave_controller.sv
// Self-checking bench for spi_slave_controller: the bench plays the SPI master.
module tb_spi_slave_controller;

  localparam int H = 8;  // sck half period in clk cycles

  logic       clk = 1'b0, reset = 1'b1;
  logic       cs_n_i = 1'b1, sck_i = 1'b0, mosi_i = 1'b0, tx_load_i = 1'b0;
  logic [7:0] tx_data_i = 8'h00;
  logic       miso_o, tx_ready_o, rx_valid_o, busy_o, underrun_o, frame_err_o;
  logic [7:0] rx_data_o;

  spi_slave_controller dut (
    .clk        (clk),
    .reset      (reset),
    .cs_n_i     (cs_n_i),
    .sck_i      (sck_i),
    .mosi_i     (mosi_i),
    .miso_o     (miso_o),
    .tx_data_i  (tx_data_i),
    .tx_load_i  (tx_load_i),
    .tx_ready_o (tx_ready_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .busy_o     (busy_o),
    .underrun_o (underrun_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int und_cnt = 0, fe_cnt = 0;
  logic [7:0] rx_got[$];
  logic [7:0] got_miso[$];
  logic       busy_all;
  logic [7:0] f_mosi[4];
  logic       f_mid_v[4];
  logic [7:0] f_mid[4];
  logic [7:0] last_rx;

  // Event recorder, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid_o) rx_got.push_back(rx_data_o);
    if (underrun_o) und_cnt++;
    if (frame_err_o) fe_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_pulse(input logic [7:0] d);
    tx_data_i = d;
    tx_load_i = 1'b1;
    wait_cycles(1);
    tx_load_i = 1'b0;
  endtask

  // One sck period; returns miso as seen at the rising edge. The last bit of a
  // frame drops sck and releases cs_n together.
  task automatic drive_bit(input logic b, input logic last, input logic do_ld,
                           input logic [7:0] ld, output logic s);
    mosi_i = b;
    wait_cycles(2);
    if (do_ld) begin
      tx_data_i = ld;
      tx_load_i = 1'b1;
    end
    wait_cycles(1);
    tx_load_i = 1'b0;
    wait_cycles(H - 3);
    s = miso_o;
    busy_all = busy_all & busy_o;
    sck_i = 1'b1;
    wait_cycles(H);
    sck_i = 1'b0;
    if (last) cs_n_i = 1'b1;
  endtask

  // Frame of n words from f_mosi; f_mid[w] is loaded during word w when f_mid_v[w].
  // abort_bits >= 0 releases cs_n after that many sck rises in word 0.
  task automatic run_frame(input int n, input int abort_bits, input logic start_ld,
                           input logic [7:0] start_word);
    logic [7:0] cap;
    logic       s;
    cs_n_i = 1'b0;
    if (start_ld) begin
      wait_cycles(2);
      tx_pulse(start_word);
    end
    for (int w = 0; w < n; w++) begin
      cap = 8'h00;
      for (int b = 7; b >= 0; b--) begin
        if (abort_bits >= 0 && (7 - b) == abort_bits) begin
          wait_cycles(H);
          cs_n_i = 1'b1;
          wait_cycles(4 * H);
          return;
        end
        drive_bit(f_mosi[w][b], (w == n - 1) && (b == 0), (b == 4) && f_mid_v[w], f_mid[w], s);
        cap = {cap[6:0], s};
      end
      got_miso.push_back(cap);
    end
    wait_cycles(4 * H);
  endtask

  task automatic clear_mid();
    for (int i = 0; i < 4; i++) begin
      f_mid_v[i] = 1'b0;
      f_mid[i]   = 8'h00;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(3);
    checks += 7;
    if (miso_o !== 1'b0) begin failures++; $display("FAIL reset_miso got %b exp 0", miso_o); end
    if (tx_ready_o !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready_o); end
    if (rx_data_o !== 8'h00) begin failures++; $display("FAIL reset_rx_data got %h exp 00", rx_data_o); end
    if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid_o); end
    if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    if (underrun_o !== 1'b0) begin failures++; $display("FAIL reset_underrun got %b exp 0", underrun_o); end
    if (frame_err_o !== 1'b0) begin failures++; $display("FAIL reset_frame_err got %b exp 0", frame_err_o); end
    reset = 1'b0;
    wait_cycles(8);
  endtask

  task automatic test_frame_start();
    int u0, r0, m0;
    clear_mid();
    tx_pulse(8'hA5);
    wait_cycles(1);
    checks++;
    if (tx_ready_o !== 1'b0) begin failures++; $display("FAIL fs_ready_after_load got %b exp 0", tx_ready_o); end
    f_mosi[0] = 8'h3C;
    u0 = und_cnt; r0 = rx_got.size(); m0 = got_miso.size(); busy_all = 1'b1;
    run_frame(1, -1, 1'b0, 8'h00);
    checks += 7;
    if (got_miso[m0] !== 8'hA5) begin failures++; $display("FAIL fs_miso got %h exp a5", got_miso[m0]); end
    if (rx_got.size() != r0 + 1) begin failures++; $display("FAIL fs_rx_count got %0d exp %0d", rx_got.size() - r0, 1); end
    if (rx_data_o !== 8'h3C) begin failures++; $display("FAIL fs_rx_data got %h exp 3c", rx_data_o); end
    if (tx_ready_o !== 1'b1) begin failures++; $display("FAIL fs_tx_ready got %b exp 1", tx_ready_o); end
    if (und_cnt != u0) begin failures++; $display("FAIL fs_underrun got %0d exp 0", und_cnt - u0); end
    if (busy_all !== 1'b1) begin failures++; $display("FAIL fs_busy_in_frame got %b exp 1", busy_all); end
    if (busy_o !== 1'b0) begin failures++; $display("FAIL fs_busy_idle got %b exp 0", busy_o); end
    last_rx = 8'h3C;
  endtask

  task automatic test_back_to_back();
    int u0, r0, m0;
    clear_mid();
    tx_pulse(8'h81);
    wait_cycles(2);
    f_mosi[0] = 8'h11; f_mosi[1] = 8'h22;
    f_mid_v[0] = 1'b1; f_mid[0] = 8'h7E;
    u0 = und_cnt; r0 = rx_got.size(); m0 = got_miso.size();
    run_frame(2, -1, 1'b0, 8'h00);
    checks += 5;
    if (got_miso[m0] !== 8'h81) begin failures++; $display("FAIL b2b_miso0 got %h exp 81", got_miso[m0]); end
    if (got_miso[m0+1] !== 8'h7E) begin failures++; $display("FAIL b2b_miso1 got %h exp 7e", got_miso[m0+1]); end
    if (rx_got.size() != r0 + 2) begin failures++; $display("FAIL b2b_rx_count got %0d exp 2", rx_got.size() - r0); end
    else begin
      if (rx_got[r0] !== 8'h11) begin failures++; $display("FAIL b2b_rx0 got %h exp 11", rx_got[r0]); end
      if (rx_got[r0+1] !== 8'h22) begin failures++; $display("FAIL b2b_rx1 got %h exp 22", rx_got[r0+1]); end
    end
    if (und_cnt != u0) begin failures++; $display("FAIL b2b_underrun got %0d exp 0", und_cnt - u0); end
    last_rx = 8'h22;
  endtask

  task automatic test_underrun();
    int u0, m0;
    clear_mid();
    f_mosi[0] = 8'($urandom); f_mosi[1] = 8'($urandom);
    u0 = und_cnt; m0 = got_miso.size();
    run_frame(2, -1, 1'b0, 8'h00);
    checks += 4;
    if (got_miso[m0] !== 8'hFF) begin failures++; $display("FAIL ur_miso0 got %h exp ff", got_miso[m0]); end
    if (got_miso[m0+1] !== 8'hFF) begin failures++; $display("FAIL ur_miso1 got %h exp ff", got_miso[m0+1]); end
    if (und_cnt != u0 + 2) begin failures++; $display("FAIL ur_count got %0d exp 2", und_cnt - u0); end
    if (rx_data_o !== f_mosi[1]) begin failures++; $display("FAIL ur_rx_data got %h exp %h", rx_data_o, f_mosi[1]); end
    last_rx = f_mosi[1];
  endtask

  task automatic test_abort();
    int f0, r0;
    clear_mid();
    f_mosi[0] = 8'h5A;
    f0 = fe_cnt; r0 = rx_got.size();
    run_frame(1, 5, 1'b0, 8'h00);
    checks += 3;
    if (fe_cnt != f0 + 1) begin failures++; $display("FAIL ab_frame_err got %0d exp 1", fe_cnt - f0); end
    if (rx_got.size() != r0) begin failures++; $display("FAIL ab_no_rx got %0d exp 0", rx_got.size() - r0); end
    if (rx_data_o !== last_rx) begin failures++; $display("FAIL ab_rx_held got %h exp %h", rx_data_o, last_rx); end
    f_mosi[0] = 8'hC3;
    run_frame(1, -1, 1'b0, 8'h00);
    checks += 2;
    if (rx_data_o !== 8'hC3) begin failures++; $display("FAIL ab_recover got %h exp c3", rx_data_o); end
    if (fe_cnt != f0 + 1) begin failures++; $display("FAIL ab_no_extra_err got %0d exp 1", fe_cnt - f0); end
    last_rx = 8'hC3;
  endtask

  // tx_load on the frame-start load point goes straight out, no underrun.
  task automatic test_coincident_load();
    int u0, m0;
    clear_mid();
    f_mosi[0] = 8'h96;
    u0 = und_cnt; m0 = got_miso.size();
    run_frame(1, -1, 1'b1, 8'h5A);
    checks += 3;
    if (got_miso[m0] !== 8'h5A) begin failures++; $display("FAIL co_miso got %h exp 5a", got_miso[m0]); end
    if (und_cnt != u0) begin failures++; $display("FAIL co_underrun got %0d exp 0", und_cnt - u0); end
    if (tx_ready_o !== 1'b1) begin failures++; $display("FAIL co_tx_ready got %b exp 1", tx_ready_o); end
    last_rx = 8'h96;
  endtask

  task automatic test_load_ignored();
    int m0;
    clear_mid();
    tx_pulse(8'h4D);
    tx_pulse(8'hB2);
    wait_cycles(2);
    f_mosi[0] = 8'h00;
    m0 = got_miso.size();
    run_frame(1, -1, 1'b0, 8'h00);
    checks++;
    if (got_miso[m0] !== 8'h4D) begin failures++; $display("FAIL ig_miso got %h exp 4d", got_miso[m0]); end
    last_rx = 8'h00;
  endtask

  // Random frames against a slot-level model of the one-deep buffer.
  task automatic test_random();
    logic       mv;
    logic [7:0] mb;
    logic [7:0] exp_tx[4];
    int n, eu, u0, r0, m0;
    mv = 1'b0; mb = 8'h00;
    for (int fr = 0; fr < 40; fr++) begin
      n = int'($urandom_range(1, 3));
      eu = 0;
      if ($urandom_range(0, 1) == 1) begin
        tx_pulse(8'($urandom));
        if (!mv) begin mb = tx_data_i; mv = 1'b1; end
        if ($urandom_range(0, 1) == 1) begin
          tx_pulse(8'($urandom));
          if (!mv) begin mb = tx_data_i; mv = 1'b1; end
        end
      end
      wait_cycles(2);
      for (int w = 0; w < 4; w++) begin
        f_mosi[w]  = 8'($urandom);
        f_mid_v[w] = (w < n - 1) && ($urandom_range(0, 1) == 1);
        f_mid[w]   = 8'($urandom);
      end
      for (int w = 0; w < n; w++) begin
        if (mv) begin exp_tx[w] = mb; mv = 1'b0; end
        else begin exp_tx[w] = 8'hFF; eu++; end
        if (f_mid_v[w] && !mv) begin mb = f_mid[w]; mv = 1'b1; end
      end
      u0 = und_cnt; r0 = rx_got.size(); m0 = got_miso.size();
      run_frame(n, -1, 1'b0, 8'h00);
      for (int w = 0; w < n; w++) begin
        checks += 2;
        if (got_miso[m0+w] !== exp_tx[w]) begin
          failures++; $display("FAIL rnd_miso fr%0d w%0d got %h exp %h", fr, w, got_miso[m0+w], exp_tx[w]);
        end
        if (rx_got[r0+w] !== f_mosi[w]) begin
          failures++; $display("FAIL rnd_rx fr%0d w%0d got %h exp %h", fr, w, rx_got[r0+w], f_mosi[w]);
        end
      end
      checks += 3;
      if (rx_got.size() != r0 + n) begin failures++; $display("FAIL rnd_rx_count fr%0d got %0d exp %0d", fr, rx_got.size() - r0, n); end
      if (und_cnt != u0 + eu) begin failures++; $display("FAIL rnd_underrun fr%0d got %0d exp %0d", fr, und_cnt - u0, eu); end
      if (tx_ready_o !== !mv) begin failures++; $display("FAIL rnd_tx_ready fr%0d got %b exp %b", fr, tx_ready_o, !mv); end
      last_rx = f_mosi[n-1];
    end
  endtask

  task automatic test_reset_midframe();
    logic s;
    int r0, f0;
    clear_mid();
    tx_pulse(8'h3E);
    wait_cycles(2);
    r0 = rx_got.size(); f0 = fe_cnt;
    cs_n_i = 1'b0;
    for (int b = 0; b < 4; b++) drive_bit(1'b1, 1'b0, 1'b0, 8'h00, s);
    reset = 1'b1;
    wait_cycles(1);
    checks += 7;
    if (miso_o !== 1'b0) begin failures++; $display("FAIL rm_miso got %b exp 0", miso_o); end
    if (tx_ready_o !== 1'b1) begin failures++; $display("FAIL rm_tx_ready got %b exp 1", tx_ready_o); end
    if (rx_data_o !== 8'h00) begin failures++; $display("FAIL rm_rx_data got %h exp 00", rx_data_o); end
    if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL rm_rx_valid got %b exp 0", rx_valid_o); end
    if (busy_o !== 1'b0) begin failures++; $display("FAIL rm_busy got %b exp 0", busy_o); end
    if (underrun_o !== 1'b0) begin failures++; $display("FAIL rm_underrun got %b exp 0", underrun_o); end
    if (frame_err_o !== 1'b0) begin failures++; $display("FAIL rm_frame_err got %b exp 0", frame_err_o); end
    reset = 1'b0;
    busy_all = 1'b0;
    for (int b = 0; b < 8; b++) drive_bit(1'b1, 1'b0, 1'b0, 8'h00, s);
    checks += 2;
    if (rx_got.size() != r0) begin failures++; $display("FAIL rm_stale_rx got %0d exp 0", rx_got.size() - r0); end
    if (busy_o !== 1'b0) begin failures++; $display("FAIL rm_stale_busy got %b exp 0", busy_o); end
    cs_n_i = 1'b1;
    wait_cycles(4 * H);
    f_mosi[0] = 8'h6B;
    run_frame(1, -1, 1'b0, 8'h00);
    checks += 3;
    if (rx_got.size() != r0 + 1) begin failures++; $display("FAIL rm_new_rx_count got %0d exp 1", rx_got.size() - r0); end
    if (rx_data_o !== 8'h6B) begin failures++; $display("FAIL rm_new_rx got %h exp 6b", rx_data_o); end
    if (fe_cnt != f0) begin failures++; $display("FAIL rm_frame_err got %0d exp 0", fe_cnt - f0); end
  endtask

  initial begin
    test_reset();
    test_frame_start();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_coincident_load();
    test_load_ignored();
    test_random();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_controller.md
Name: spi_slave_controller

Overview:
Byte-oriented SPI responder (mode 0: CPOL=0, CPHA=0, MSB first). It is the far-end counterpart of spi_master_controller. It lets the iCE40 act as an SPI peripheral, for example for loopback testing of the master/display path or for receiving image/command bytes from an external host. SPI pins are asynchronous to clk; the block oversamples them, deserialises MOSI into rx bytes and serialises a one-deep tx buffer onto MISO.

Parameters:
WIDTH, 8, bits per SPI word
SYNC_STAGES, 2, synchroniser flops on sck/cs_n/mosi (min 2)
IDLE_FILL, 8'hFF, word shifted out when tx buffer is empty at a load point

Ports:
clk  in  1  system clock (12 MHz)
reset  in  1  reset (synchronous, active-high)
cs_n  in  1  chip select from master, active-low, async
sck  in  1  SPI clock from master, async
mosi  in  1  master-out data, async
miso  out  1  slave-out data, registered
tx_data  in  WIDTH  word to send in next frame slot
tx_load  in  1  write strobe for tx_data; accepted only when tx_ready=1
tx_ready  out  1  tx buffer empty
rx_data  out  WIDTH  last complete received word, held until next
rx_valid  out  1  one-cycle pulse: rx_data updated
busy  out  1  synchronised cs_n low (frame active)
underrun  out  1  one-cycle pulse: IDLE_FILL sent because buffer empty
frame_err  out  1  one-cycle pulse: cs_n deasserted mid-word

Behaviour:
- Reset: miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, underrun=0, frame_err=0; bit_cnt=0, shift regs=0, state=IDLE.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised sck/cs_n. Requirement on the master: sck high and low phases are each >= SYNC_STAGES+2 clk cycles, and the first sck rise comes >= SYNC_STAGES+2 cycles after cs_n falls. spi_master_controller with CLK_DIVIDER=6 meets this.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE on synced cs_n fall.
  - Load point: tx_shift <= buffer, or IDLE_FILL plus an underrun pulse if the buffer is empty. miso <= loaded MSB. bit_cnt=0.
- ACTIVE, synced sck rise:
  - rx_shift <= {rx_shift[WIDTH-2:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches WIDTH: rx_data <= completed word, rx_valid=1 for one cycle, bit_cnt <= 0, word_done=1.
- ACTIVE, synced sck fall:
  - If word_done: this is a load point (same rules as frame start); clear word_done.
  - Else: tx_shift <<= 1 and miso <= next bit.
- rx_valid latency: SYNC_STAGES+1 clk cycles after the WIDTH-th sck rise at the pin.
- ACTIVE -> IDLE on synced cs_n rise.
  - If 0 < bit_cnt < WIDTH: frame_err pulse; partial word discarded, no rx_valid.
  - A word already taken from the buffer is dropped.
  - miso <= 0; word_done cleared.
- sck edges while IDLE are ignored.
- tx buffer:
  - tx_load while tx_ready=1 captures tx_data and drops tx_ready next cycle.
  - tx_load while tx_ready=0 is ignored; the held word is unchanged.
  - A load point empties the buffer, so tx_ready=1 next cycle.
  - tx_load and a load point in the same cycle: tx_data goes directly into tx_shift, the buffer stays empty, and there is no underrun.
- busy = synced cs_n inverted, registered.
- A cs_n rise coinciding with an sck edge: the cs_n event wins and the sck edge is ignored.
- Reset mid-frame returns the block to IDLE with reset values. The block waits for a fresh cs_n fall, ignoring the current low cs_n.

Decomposition:
- Package spi_pkg: SPI_MODE0 constant, default word width, default IDLE_FILL.
- Sub-module sync_edge_detect: SYNC_STAGES synchroniser with rise/fall pulse outputs. Instanced for sck and cs_n; mosi uses its synchronised level only.

Test Plan:
- Frame start: tx_load 8'hA5 before cs_n fall; master sends 8'h3C -> miso bits 1,0,1,0,0,1,0,1 sampled on sck rises; rx_valid one pulse with rx_data=8'h3C; tx_ready=1 after cs_n fall.
- Back-to-back words: preload 8'h81, load 8'h7E during word 1; master sends 8'h11, 8'h22 in one frame -> miso 8'h81 then 8'h7E; two rx_valid pulses, rx_data 8'h11 then 8'h22; no underrun.
- Underrun: no tx_load, 2-word frame -> miso 8'hFF twice; underrun pulses twice (frame start, word boundary).
- Abort: cs_n rises after 5 sck rises -> frame_err pulse, no rx_valid, rx_data unchanged; next full frame with 8'hC3 -> rx_data=8'hC3.
- Loopback: spi_master_controller (CLK_DIVIDER=6) drives this block over 256 random words with random tx preloads -> every master data_out equals the slave's preloaded word; every rx_data equals the master's data_in.
- Reset at bit 4 of a word -> all outputs at reset values next cycle; rx_valid does not fire until a new cs_n fall plus 8 sck rises.
